// File: rtl/gauss5x5_blur_if.sv
// Window-in / pixel-out bundle for the 5x5 Gaussian blur stage.
// The producer uses the master modport; the blur core uses the slave modport.
interface gauss5x5_blur_if;
    logic         in_valid;
    logic         in_sof;
    logic [199:0] in_win;
    logic         out_valid;
    logic [7:0]   out_pixel;
    logic         out_eol;
    logic         out_eof;

    modport master (
        output in_valid, in_sof, in_win,
        input  out_valid, out_pixel, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_sof, in_win,
        output out_valid, out_pixel, out_eol, out_eof
    );
endinterface

// File: rtl/gauss5x5_blur.sv
// Pipelined 5x5 Gaussian blur ([1 4 6 4 1] outer product, /256 with rounding), one pixel per clock.
// Optional macro BORDER_CLAMP_EN: border pixels pass the raw centre pixel instead of black.
module gauss5x5_blur #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic           clk,
    input  logic           reset,
    gauss5x5_blur_if.slave blur
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_HI   = COL_W'(IMG_WIDTH - 3);
    localparam logic [ROW_W-1:0] ROW_HI   = ROW_W'(IMG_HEIGHT - 3);

    // Frame position tracking
    logic [COL_W-1:0] col_reg, col_next, cur_col;
    logic [ROW_W-1:0] row_reg, row_next, cur_row;
    logic             cur_border, cur_eol, cur_eof;

    always_comb begin
        cur_col    = blur.in_sof ? '0 : col_reg;
        cur_row    = blur.in_sof ? '0 : row_reg;
        cur_border = (cur_row < ROW_W'(2)) || (cur_row > ROW_HI) ||
                     (cur_col < COL_W'(2)) || (cur_col > COL_HI);
        cur_eol    = (cur_col == COL_LAST);
        cur_eof    = cur_eol && (cur_row == ROW_LAST);
        col_next   = col_reg;
        row_next   = row_reg;
        if (blur.in_valid) begin
            if (cur_eol) begin
                col_next = '0;
                row_next = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_next = cur_col + COL_W'(1);
                row_next = cur_row;
            end
        end else if (blur.in_sof) begin
            col_next = '0;
            row_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // Stage 0: register the window together with its position flags
    logic         v0_reg, bord0_reg, eol0_reg, eof0_reg;
    logic [199:0] win_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            v0_reg    <= 1'b0;
            bord0_reg <= 1'b0;
            eol0_reg  <= 1'b0;
            eof0_reg  <= 1'b0;
        end else begin
            v0_reg    <= blur.in_valid;
            bord0_reg <= blur.in_valid && cur_border;
            eol0_reg  <= blur.in_valid && cur_eol;
            eof0_reg  <= blur.in_valid && cur_eof;
        end
        win_reg <= blur.in_win;
    end

    // Stage 1: horizontal [1 4 6 4 1] per row, row 0 in the top 40 bits
    logic [11:0] h_next [5];
    logic [11:0] h_reg  [5];
    logic        v1_reg, bord1_reg, eol1_reg, eof1_reg;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_row
            logic [39:0] row_px;
            assign row_px      = win_reg[199 - 40*gi -: 40];
            assign h_next[gi]  = 12'(row_px[39:32])
                               + (12'(row_px[31:24]) << 2)
                               + 12'(row_px[23:16]) * 12'd6
                               + (12'(row_px[15:8]) << 2)
                               + 12'(row_px[7:0]);
            always_ff @(posedge clk) begin
                h_reg[gi] <= h_next[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg    <= 1'b0;
            bord1_reg <= 1'b0;
            eol1_reg  <= 1'b0;
            eof1_reg  <= 1'b0;
        end else begin
            v1_reg    <= v0_reg;
            bord1_reg <= bord0_reg;
            eol1_reg  <= eol0_reg;
            eof1_reg  <= eof0_reg;
        end
    end

    // Stage 2: vertical [1 4 6 4 1] over the row sums
    logic [15:0] s_reg, s_next;
    logic        v2_reg, bord2_reg, eol2_reg, eof2_reg;

    assign s_next = 16'(h_reg[0])
                  + (16'(h_reg[1]) << 2)
                  + 16'(h_reg[2]) * 16'd6
                  + (16'(h_reg[3]) << 2)
                  + 16'(h_reg[4]);

    always_ff @(posedge clk) begin
        if (reset) begin
            v2_reg    <= 1'b0;
            bord2_reg <= 1'b0;
            eol2_reg  <= 1'b0;
            eof2_reg  <= 1'b0;
        end else begin
            v2_reg    <= v1_reg;
            bord2_reg <= bord1_reg;
            eol2_reg  <= eol1_reg;
            eof2_reg  <= eof1_reg;
        end
        s_reg <= s_next;
    end

    // Stage 3: round and normalise; weights sum to 256 so the result always fits 8 bits
    logic [7:0] filt_pix, border_pix, sel_pix;

    assign filt_pix = 8'((17'(s_reg) + 17'd128) >> 8);

`ifdef BORDER_CLAMP_EN
    logic [7:0] ctr1_reg, ctr2_reg;
    always_ff @(posedge clk) begin
        ctr1_reg <= win_reg[103:96];
        ctr2_reg <= ctr1_reg;
    end
    assign border_pix = ctr2_reg;
`else
    assign border_pix = 8'd0;
`endif

    assign sel_pix = bord2_reg ? border_pix : filt_pix;

    logic       out_valid_reg, out_eol_reg, out_eof_reg;
    logic [7:0] out_pixel_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_pixel_reg <= 8'd0;
            out_eol_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
        end else begin
            out_valid_reg <= v2_reg;
            out_pixel_reg <= v2_reg ? sel_pix : 8'd0;
            out_eol_reg   <= v2_reg && eol2_reg;
            out_eof_reg   <= v2_reg && eof2_reg;
        end
    end

    assign blur.out_valid = out_valid_reg;
    assign blur.out_pixel = out_pixel_reg;
    assign blur.out_eol   = out_eol_reg;
    assign blur.out_eof   = out_eof_reg;
endmodule
